// File: rtl/cve2_cg_ctrl_pkg.sv
// Shared types and sizing helpers for the core clock-gate controller.
// The run and wake phases never overlap, so one counter serves both.
package cve2_cg_ctrl_pkg;

   typedef enum logic [1:0] {
      CG_ACTIVE    = 2'd0,
      CG_IDLE_WAIT = 2'd1,
      CG_GATED     = 2'd2,
      CG_WAKE      = 2'd3
   } cg_state_e;

   // Wide enough to hold max(idle, wake); callers guarantee both are >= 1.
   function automatic int unsigned cg_cnt_width(input int unsigned idle_cycles,
                                                input int unsigned wake_cycles);
      int unsigned max_cycles;
      max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
      return $clog2(max_cycles + 1);
   endfunction

endpackage

// File: rtl/cve2_cg_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module cve2_cg_sat_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cve2_clock_gate_ctrl.sv
// Drives the core clock-gate enable: gates after a run of idle cycles, and on wake
// keeps the clock running for a settling window before pulsing wake_done_o.
module cve2_clock_gate_ctrl
   import cve2_cg_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_gate_en_i,
   input  logic             core_sleep_i,
   input  logic             wakeup_i,
   input  logic             debug_req_i,
   input  logic             test_en_i,
   input  logic             cnt_clr_i,
   output logic             clk_en_o,
   output logic             gated_o,
   output logic             wake_done_o,
   output logic [CNT_W-1:0] gated_cycles_o
);

   localparam int unsigned    CW        = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);
   localparam logic [CW-1:0]  IDLE_LAST = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0]  WAKE_LAST = CW'(WAKE_CYCLES - 1);

   cg_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_en_q, clk_en_d;
   logic          gated_q, gated_d;
   logic          wake_done_q, wake_done_d;
   logic          qualify;
   logic          wake;

   // Wake sources are excluded from qualify, so a conflict always resolves to wake.
   assign qualify = cfg_gate_en_i & core_sleep_i & ~wakeup_i & ~debug_req_i;
   assign wake    = wakeup_i | debug_req_i | ~cfg_gate_en_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CG_ACTIVE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         CG_ACTIVE: begin
            if (qualify) begin
               if (IDLE_CYCLES == 1) begin
                  state_d = CG_GATED;
                  cnt_d   = '0;
               end else begin
                  state_d = CG_IDLE_WAIT;
                  cnt_d   = CW'(1);
               end
            end
         end
         CG_IDLE_WAIT: begin
            if (qualify && (cnt_q == IDLE_LAST)) begin
               state_d = CG_GATED;
               cnt_d   = '0;
            end else if (qualify) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               state_d = CG_ACTIVE;
               cnt_d   = '0;
            end
         end
         CG_GATED: begin
            if (wake) begin
               state_d = CG_WAKE;
               cnt_d   = '0;
            end
         end
         CG_WAKE: begin
            // Sleep and further wake sources are ignored until the window closes.
            if (cnt_q == WAKE_LAST) begin
               state_d = CG_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = CG_ACTIVE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      clk_en_d    = (state_d != CG_GATED);
      gated_d     = (state_d == CG_GATED);
      wake_done_d = (state_q == CG_WAKE) && (state_d == CG_ACTIVE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_en_q    <= 1'b1;
         gated_q     <= 1'b0;
         wake_done_q <= 1'b0;
      end else begin
         clk_en_q    <= clk_en_d;
         gated_q     <= gated_d;
         wake_done_q <= wake_done_d;
      end
   end

   cve2_cg_sat_cnt #(
      .W (CNT_W)
   ) u_gated_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr_i),
      .en_i   (state_q == CG_GATED),
      .cnt_o  (gated_cycles_o)
   );

   // Scan force-enable bypasses the FSM entirely.
   assign clk_en_o    = clk_en_q | test_en_i;
   assign gated_o     = gated_q;
   assign wake_done_o = wake_done_q;

endmodule

// File: tb/tb_cve2_clock_gate_ctrl.sv
// Directed bench for cve2_clock_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
module tb_cve2_clock_gate_ctrl;

   logic clk;
   logic rst_ni;
   logic cfg_gate_en, core_sleep, wakeup, debug_req, test_en, cnt_clr;
   logic clk_en, gated, wake_done;
   logic [31:0] gated_cycles;
   logic clk_en3, gated3, wake_done3;
   logic [2:0]  gated_cycles3;

   int n_pass;
   int n_total;

   cve2_clock_gate_ctrl #(
      .IDLE_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (32)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .cfg_gate_en_i  (cfg_gate_en),
      .core_sleep_i   (core_sleep),
      .wakeup_i       (wakeup),
      .debug_req_i    (debug_req),
      .test_en_i      (test_en),
      .cnt_clr_i      (cnt_clr),
      .clk_en_o       (clk_en),
      .gated_o        (gated),
      .wake_done_o    (wake_done),
      .gated_cycles_o (gated_cycles)
   );

   cve2_clock_gate_ctrl #(
      .IDLE_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (3)
   ) dut3 (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .cfg_gate_en_i  (cfg_gate_en),
      .core_sleep_i   (core_sleep),
      .wakeup_i       (wakeup),
      .debug_req_i    (debug_req),
      .test_en_i      (test_en),
      .cnt_clr_i      (cnt_clr),
      .clk_en_o       (clk_en3),
      .gated_o        (gated3),
      .wake_done_o    (wake_done3),
      .gated_cycles_o (gated_cycles3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // inputs = {cfg, sleep, wakeup, debug, test_en, cnt_clr}; outs = {clk_en, gated, wake_done}
   typedef struct packed {
      logic [5:0]  inputs;
      logic [2:0]  outs;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      cfg_gate_en = 1'b0;
      core_sleep  = 1'b0;
      wakeup      = 1'b0;
      debug_req   = 1'b0;
      test_en     = 1'b0;
      cnt_clr     = 1'b0;
      step();
      chk("rst_clk_en", {31'b0, clk_en}, 32'd1);
      chk("rst_gated", {31'b0, gated}, 32'd0);
      chk("rst_wake_done", {31'b0, wake_done}, 32'd0);
      chk("rst_cnt", gated_cycles, 32'd0);
      @(negedge clk);
      rst_ni      = 1'b1;
      cfg_gate_en = 1'b1;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      vecs[0]  = '{6'b110000, 3'b100, 32'd0};
      vecs[1]  = '{6'b110000, 3'b100, 32'd0};
      vecs[2]  = '{6'b110000, 3'b100, 32'd0};
      vecs[3]  = '{6'b110000, 3'b010, 32'd0};
      for (int i = 4; i < 10; i++) vecs[i] = '{6'b110000, 3'b010, 32'(i - 3)};
      vecs[10] = '{6'b111000, 3'b100, 32'd7};
      vecs[11] = '{6'b110000, 3'b100, 32'd7};
      vecs[12] = '{6'b110000, 3'b101, 32'd7};
      vecs[13] = '{6'b110000, 3'b100, 32'd7};
      vecs[14] = '{6'b100000, 3'b100, 32'd7};
      vecs[15] = '{6'b110000, 3'b100, 32'd7};
      vecs[16] = '{6'b110000, 3'b100, 32'd7};
      vecs[17] = '{6'b110000, 3'b100, 32'd7};
      vecs[18] = '{6'b110010, 3'b110, 32'd7};
      vecs[19] = '{6'b100100, 3'b100, 32'd8};
      vecs[20] = '{6'b100000, 3'b100, 32'd8};
      vecs[21] = '{6'b100000, 3'b101, 32'd8};
      vecs[22] = '{6'b100000, 3'b100, 32'd8};

      // Gate then wake, interrupted re-idle, test force-enable, debug wake.
      do_reset();
      for (int i = 0; i < NV; i++) begin
         {cfg_gate_en, core_sleep, wakeup, debug_req, test_en, cnt_clr} = vecs[i].inputs;
         step();
         chk($sformatf("vec%0d_clk_en", i), {31'b0, clk_en}, {31'b0, vecs[i].outs[2]});
         chk($sformatf("vec%0d_gated", i), {31'b0, gated}, {31'b0, vecs[i].outs[1]});
         chk($sformatf("vec%0d_wake_done", i), {31'b0, wake_done}, {31'b0, vecs[i].outs[0]});
         chk($sformatf("vec%0d_cnt", i), gated_cycles, vecs[i].cnt);
         $display("vec %0d: in=%b clk_en=%b gated=%b wake_done=%b cnt=%0d",
                  i, vecs[i].inputs, clk_en, gated, wake_done, gated_cycles);
      end

      // Interrupted idle: sleep drops at edge 3, gating happens after edge 7.
      do_reset();
      for (int e = 0; e < 8; e++) begin
         core_sleep = (e != 3);
         step();
         chk($sformatf("intr_e%0d_clk_en", e), {31'b0, clk_en}, (e == 7) ? 32'd0 : 32'd1);
      end
      $display("interrupted idle: clk_en=%b after edge 7", clk_en);

      // Wake source at the terminal idle edge keeps the clock running.
      do_reset();
      core_sleep = 1'b1;
      for (int e = 0; e < 7; e++) begin
         wakeup = (e == 3);
         step();
         chk($sformatf("term_e%0d_gated", e), {31'b0, gated}, 32'd0);
         chk($sformatf("term_e%0d_clk_en", e), {31'b0, clk_en}, 32'd1);
      end
      wakeup = 1'b0;
      core_sleep = 1'b0;
      $display("terminal conflict: gated=%b clk_en=%b", gated, clk_en);

      // Config drop while gated still goes through the full wake window.
      do_reset();
      core_sleep = 1'b1;
      for (int e = 0; e < 4; e++) step();
      chk("cfgdrop_gated", {31'b0, gated}, 32'd1);
      cfg_gate_en = 1'b0;
      for (int e = 4; e < 8; e++) begin
         step();
         chk($sformatf("cfgdrop_e%0d_wake_done", e), {31'b0, wake_done}, (e == 6) ? 32'd1 : 32'd0);
         chk($sformatf("cfgdrop_e%0d_clk_en", e), {31'b0, clk_en}, 32'd1);
      end
      $display("config drop: wake_done=%b gated=%b", wake_done, gated);

      // Asynchronous reset while gated takes effect without a clock edge.
      do_reset();
      core_sleep = 1'b1;
      for (int e = 0; e < 6; e++) step();
      chk("areset_pre_cnt", gated_cycles, 32'd2);
      chk("areset_pre_clk_en", {31'b0, clk_en}, 32'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("areset_clk_en", {31'b0, clk_en}, 32'd1);
      chk("areset_gated", {31'b0, gated}, 32'd0);
      chk("areset_cnt", gated_cycles, 32'd0);
      chk("areset_wake_done", {31'b0, wake_done}, 32'd0);
      $display("async reset: clk_en=%b gated=%b cnt=%0d", clk_en, gated, gated_cycles);

      // Narrow counter saturates at 7, then clear wins over increment.
      do_reset();
      core_sleep = 1'b1;
      for (int e = 0; e < 11; e++) step();
      chk("sat_e10_cnt3", {29'b0, gated_cycles3}, 32'd7);
      for (int e = 11; e < 14; e++) step();
      chk("sat_e13_cnt3", {29'b0, gated_cycles3}, 32'd7);
      chk("sat_e13_cnt32", gated_cycles, 32'd10);
      chk("sat_e13_gated3", {31'b0, gated3}, 32'd1);
      cnt_clr = 1'b1;
      step();
      chk("clr_cnt3", {29'b0, gated_cycles3}, 32'd0);
      chk("clr_cnt32", gated_cycles, 32'd0);
      cnt_clr = 1'b0;
      step();
      chk("post_clr_cnt3", {29'b0, gated_cycles3}, 32'd1);
      $display("saturation: cnt3=%0d cnt32=%0d", gated_cycles3, gated_cycles);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cve2_clock_gate_ctrl.md
# cve2_clock_gate_ctrl

- Generates the enable for the core clock gate (`cve2_clock_gate.en_i`).
- Watches the core sleep/WFI indication and a set of wake sources on the free-running clock.
- Gates the core clock after a programmable idle run, then restores it with a fixed settling window and a wake-done pulse.
- Sits in the core power/clock domain next to the gate cell and is always clocked by the ungated clock.

## Interface
Parameters:
- `IDLE_CYCLES`, default 16: consecutive qualifying cycles before gating; ≥1.
- `WAKE_CYCLES`, default 2: cycles the clock runs before `wake_done_o`; ≥1.
- `CNT_W`, default 32: width of the gated-cycle statistics counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  free-running clock (never the gated clock).
- `rst_ni`  in  1  asynchronous active-low reset.
- `cfg_gate_en_i`  in  1  gating permitted.
- `core_sleep_i`  in  1  core idle/WFI, synchronous to `clk_i`.
- `wakeup_i`  in  1  pending interrupt, synchronous to `clk_i`.
- `debug_req_i`  in  1  debug request, synchronous to `clk_i`.
- `test_en_i`  in  1  scan/test force-enable.
- `cnt_clr_i`  in  1  synchronous clear of the statistics counter.
- `clk_en_o`  out  1  enable to the clock gate.
- `gated_o`  out  1  high while in GATED.
- `wake_done_o`  out  1  one-cycle pulse: core clock stable after wake.
- `gated_cycles_o`  out  CNT_W  saturating count of gated cycles.

## Operation
- qualify = `cfg_gate_en_i & core_sleep_i & ~wakeup_i & ~debug_req_i`.
- wake = `wakeup_i | debug_req_i | ~cfg_gate_en_i`.

States:
- **ACTIVE**
  - `clk_en_q`=1.
  - If qualify: go to GATED when `IDLE_CYCLES`==1, else go to IDLE_WAIT with run count = 1.
- **IDLE_WAIT**
  - `clk_en_q`=1.
  - If qualify and run count == `IDLE_CYCLES`-1: go to GATED.
  - Else if qualify: increment the run count.
  - Else: go to ACTIVE with run count cleared.
- **GATED**
  - `clk_en_q`=0.
  - If wake: go to WAKE with wake count = 0.
- **WAKE**
  - `clk_en_q`=1.
  - `core_sleep_i` is ignored.
  - Increment the wake count each cycle.
  - When the count reaches `WAKE_CYCLES`-1: go to ACTIVE and assert `wake_done_o` for exactly one cycle.

Outputs:
- `clk_en_o` = `clk_en_q | test_en_i`. This is the only combinational path. `test_en_i` does not affect the FSM or the counters.
- `gated_o` = (state == GATED), registered.

Statistics counter:
- Increments at every edge where the state is GATED.
- Saturates at all-ones.
- `cnt_clr_i` wins over increment.

Boundary rules:
- Qualify and wake conflicts: qualify already excludes wake, so wake wins.
- A wake source at the IDLE_WAIT terminal edge returns the block to ACTIVE; it does not gate.
- Dropping `cfg_gate_en_i` in GATED wakes the core through WAKE; the WAKE window is never skipped.
- A wake source asserted during WAKE has no extra effect.

## Timing
- All outputs are registered, except the `test_en_i` OR term on `clk_en_o`.
- Reset values:
  - State ACTIVE.
  - `clk_en_o`=1 (when `test_en_i`=0).
  - `gated_o`=0.
  - `wake_done_o`=0.
  - `gated_cycles_o`=0.
  - Internal counters 0.
- Gate latency: if qualify is sampled true at `IDLE_CYCLES` consecutive edges k…k+IDLE_CYCLES-1, `clk_en_o` is low from edge k+IDLE_CYCLES-1.
- Ungate latency: wake sampled at edge m (state GATED) gives `clk_en_o` high after edge m.
- Wake-done timing: `wake_done_o` is high in the cycle after edge m+WAKE_CYCLES.
- Asynchronous reset mid-operation (any state, including GATED) returns the block to ACTIVE with `clk_en_o`=1 immediately. No wake pulse is generated.

## Structure
- Package `cve2_cg_ctrl_pkg`:
  - State enum (ACTIVE, IDLE_WAIT, GATED, WAKE).
  - Run/wake counter width function `$clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)`.
- Sub-module `cve2_cg_sat_cnt`: parameterized saturating up-counter with clear and enable, used for `gated_cycles_o`.
- Top-level: FSM plus one shared run/wake counter.

## Test plan
All scenarios use IDLE_CYCLES=4, WAKE_CYCLES=2.
- **Gate then wake:** reset released, `cfg_gate_en_i`=1, `core_sleep_i`=1 from edge 0, `wakeup_i` pulsed at edge 10 → `clk_en_o` low after edge 3, high after edge 10; `wake_done_o` high only in the cycle after edge 12; `gated_cycles_o`=7.
- **Interrupted idle:** `core_sleep_i` high at edges 0–2, low at 3, high again from 4 → `clk_en_o` stays 1 through edge 6, falls after edge 7.
- **Terminal-edge conflict:** `core_sleep_i`=1 from edge 0, `wakeup_i`=1 at edge 3 → no gating; state back to ACTIVE; `gated_o` never asserts.
- **Config drop and test mode:** in GATED, deassert `cfg_gate_en_i` → WAKE entered, `wake_done_o` pulses 2 cycles later. Separately, `test_en_i`=1 in GATED → `clk_en_o`=1 combinationally while `gated_o` stays 1.
- **Async reset in GATED:** `rst_ni` low while GATED → `clk_en_o`=1, `gated_o`=0, `gated_cycles_o`=0 without a clock edge.
- **Counter saturation and clear:** CNT_W=3, hold GATED 10 cycles → `gated_cycles_o`=7 and holds; `cnt_clr_i`=1 in GATED → next value 0.
